// File: rtl/mwadd_pkg.sv
// Shared types and sizing helpers for the multi-word carry-chaining adder.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mwadd_state_e;

  // Chunk index width; a single-chunk configuration still needs a 1-bit index.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mwadd_chunk.sv
// Combinational WIDTH-bit chunk adder with carry into and out of the chunk MSB.
module mwadd_chunk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    // Sum bit is a^b^carry_in, so the MSB carry-in falls out of the sum bit.
    msb_cin   = a[WIDTH-1] ^ b[WIDTH-1] ^ s[WIDTH-1];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two WIDTH*WORDS operands one chunk per clock, LSB chunk first.
// Define MWADD_OVF_EN to add a registered two's-complement overflow output.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
`ifdef MWADD_OVF_EN
  output logic                   out_ovf,
`endif
  output logic                   busy
);

  localparam int OPW = WIDTH * WORDS;
  localparam int IW  = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  mwadd_state_e   state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic           carry_q;
  logic [OPW-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] chunk_s;
  logic           chunk_c;
  logic           last_chunk;
`ifdef MWADD_OVF_EN
  logic           msb_cin;
  logic           ovf_q;
`endif

  assign last_chunk = (idx_q == LAST);

  mwadd_chunk #(.WIDTH(WIDTH)) u_chunk (
    .a       (a_q[int'(idx_q)*WIDTH +: WIDTH]),
    .b       (b_q[int'(idx_q)*WIDTH +: WIDTH]),
    .cin     (carry_q),
    .s       (chunk_s),
    .cout    (chunk_c),
`ifdef MWADD_OVF_EN
    .msb_cin (msb_cin)
`else
    .msb_cin ()
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode state only; no path from in_valid/out_ready.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    out_cout  = out_valid & carry_q;
    out_sum   = sum_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_b;
          carry_q <= in_cin;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[int'(idx_q)*WIDTH +: WIDTH] <= chunk_s;
          carry_q <= chunk_c;
          if (!last_chunk) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MWADD_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               ovf_q <= 1'b0;
    else if (state_q == RUN && last_chunk)  ovf_q <= msb_cin ^ chunk_c;
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed-vector bench for multiword_add_seq (WIDTH=8, WORDS=4).
module tb_multiword_add_seq;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int BOUND = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin;
  logic        out_valid, out_ready, out_cout, busy;
  logic [31:0] in_a, in_b, out_sum;
`ifdef MWADD_OVF_EN
  logic        out_ovf;
`endif

  int vecs = 0;
  int errs = 0;

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef MWADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drives one operand set, waits for the result, then transfers it.
  // lat = cycles from acceptance edge to out_valid visible, -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       output logic [31:0] s, output logic co, output logic ov,
                       output int lat);
    int n;
    lat = -1; s = '0; co = 1'b0; ov = 1'b0;
    in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < BOUND) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < BOUND) begin @(posedge clk); #1; n++; end
    if (out_valid) begin
      lat = n; s = out_sum; co = out_cout;
`ifdef MWADD_OVF_EN
      ov = out_ovf;
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    #12;
    vecs++;
    if ({in_ready, out_valid, busy, out_cout} !== 4'b1000) begin
      errs++;
      $display("FAIL reset_flags got rdy/vld/busy/cout=%b want 1000",
               {in_ready, out_valid, busy, out_cout});
    end
    vecs++;
    if (out_sum !== 32'h0) begin
      errs++; $display("FAIL reset_sum got %h want 00000000", out_sum);
    end
`ifdef MWADD_OVF_EN
    vecs++;
    if (out_ovf !== 1'b0) begin
      errs++; $display("FAIL reset_ovf got %b want 0", out_ovf);
    end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] s; logic co, ov; int lat;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, s, co, ov, lat);
    vecs++;
    if (lat !== WORDS) begin errs++; $display("FAIL basic_latency got %0d want %0d", lat, WORDS); end
    vecs++;
    if (s !== 32'h0000_0100) begin errs++; $display("FAIL basic_sum got %h want 00000100", s); end
    vecs++;
    if (co !== 1'b0) begin errs++; $display("FAIL basic_cout got %b want 0", co); end
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL basic_after_xfer got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple;
    logic [31:0] s; logic co, ov; int lat;
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s, co, ov, lat);
    vecs++;
    if (s !== 32'h0 || co !== 1'b1 || lat !== WORDS) begin
      errs++;
      $display("FAIL ripple got sum=%h cout=%b lat=%0d want sum=00000000 cout=1 lat=%0d", s, co, lat, WORDS);
    end
  endtask

  task automatic test_stall;
    int n;
    in_a = 32'h1234_5670; in_b = 32'h0000_0008; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < BOUND) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_sum !== 32'h1234_5678 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold cyc%0d got vld=%b sum=%h cout=%b rdy=%b want 1 12345678 0 0",
                 k, out_valid, out_sum, out_cout, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL stall_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    // Second operand set held valid throughout RUN/DONE; must wait its turn.
    in_a = 32'h0000_FFFF; in_b = 32'h0000_0001;
    vecs++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL b2b_run_flags got rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    n = 0;
    while (!out_valid && n < BOUND) begin @(posedge clk); #1; n++; end
    vecs++;
    if (out_sum !== 32'h3333_3333 || out_cout !== 1'b0) begin
      errs++; $display("FAIL b2b_first got sum=%h cout=%b want 33333333 0", out_sum, out_cout);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_back got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < BOUND) begin @(posedge clk); #1; n++; end
    vecs++;
    if (out_sum !== 32'h0001_0000 || out_cout !== 1'b0 || n !== WORDS) begin
      errs++;
      $display("FAIL b2b_second got sum=%h cout=%b lat=%0d want 00010000 0 %0d", out_sum, out_cout, n, WORDS);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] s; logic co, ov; int lat;
    in_a = 32'h0000_0005; in_b = 32'h0000_0006; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vecs++;
    if ({in_ready, out_valid, busy, out_cout} !== 4'b1000 || out_sum !== 32'h0) begin
      errs++;
      $display("FAIL midrun_reset got rdy/vld/busy/cout=%b sum=%h want 1000 00000000",
               {in_ready, out_valid, busy, out_cout}, out_sum);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, s, co, ov, lat);
    vecs++;
    if (s !== 32'h3 || co !== 1'b0 || lat !== WORDS) begin
      errs++; $display("FAIL midrun_after got sum=%h cout=%b lat=%0d want 00000003 0 %0d", s, co, lat, WORDS);
    end
  endtask

`ifdef MWADD_OVF_EN
  task automatic test_ovf;
    logic [31:0] s; logic co, ov; int lat;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, co, ov, lat);
    vecs++;
    if (s !== 32'h8000_0000 || ov !== 1'b1 || co !== 1'b0) begin
      errs++; $display("FAIL ovf_pos got sum=%h ovf=%b cout=%b want 80000000 1 0", s, ov, co);
    end
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, co, ov, lat);
    vecs++;
    if (s !== 32'h0 || ov !== 1'b0 || co !== 1'b1) begin
      errs++; $display("FAIL ovf_wrap got sum=%h ovf=%b cout=%b want 00000000 0 1", s, ov, co);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MWADD_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Carry-chaining sequencer that adds two wide operands one WIDTH-bit chunk per clock, least-significant chunk first, feeding each chunk's carry-out into the next chunk. It sits between the operand source and the result consumer in the adder datapath. It uses valid/ready handshakes on both sides, so it can be placed directly ahead of the registered n-bit adder stage or replace it for wide words.

## Interface
- WIDTH, 8: chunk width in bits (≥1)
- WORDS, 4: chunks per operand (≥1); operand width is WIDTH*WORDS
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set presented
- in_ready  output  1  sequencer can accept an operand set
- in_a  input  WIDTH*WORDS  operand A
- in_b  input  WIDTH*WORDS  operand B
- in_cin  input  1  carry-in to chunk 0
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_sum  output  WIDTH*WORDS  sum, modulo 2^(WIDTH*WORDS)
- out_cout  output  1  carry-out of the top chunk
- busy  output  1  high in RUN or DONE

## Operation
- FSM states:
  - IDLE: in_ready=1. If in_valid is high, capture in_a, in_b and in_cin into registers, set chunk index idx=0 and carry=in_cin, then go to RUN.
  - RUN: compute {c, s} = a[idx] + b[idx] + carry. Write s to sum chunk idx and load carry<=c. If idx==WORDS-1, go to DONE; otherwise increment idx.
  - DONE: out_valid=1 and out_cout=carry. If out_ready is high, go to IDLE.
- Handshake rules:
  - in_ready is high only in IDLE, and in_valid is ignored in every other state.
  - While out_valid is high and out_ready is low, out_sum and out_cout hold stable.
  - out_valid stays high until the transfer completes.
- idx is $clog2(WORDS) bits wide, with a minimum of 1. It never wraps past WORDS-1.
- WORDS=1: RUN lasts exactly one cycle.
- Sum chunks above idx keep their previous value until written. out_sum is only meaningful while out_valid is high.
- Reset (rst low, at any time including mid-RUN):
  - State goes to IDLE.
  - idx, carry, operand registers and out_sum clear to 0.
  - out_valid=0, out_cout=0, busy=0, in_ready=1.
  - Any in-flight operation is discarded.

## Timing
- Acceptance edge is T0 (IDLE with in_valid high).
- RUN occupies edges T1..TWORDS. out_valid rises after edge TWORDS, i.e. visible WORDS cycles after acceptance.
- Result transfer happens at the first edge with out_valid and out_ready both high. in_ready returns high in the following cycle.
- Minimum initiation interval is WORDS+2 cycles.
- in_ready and out_valid are decoded from state registers only, with no combinational path from in_valid or out_ready.

## Configuration
- MWADD_OVF_EN defined:
  - Adds output port out_ovf (1 bit) and a registered ovf flag.
  - In the RUN cycle with idx==WORDS-1, ovf<=carry into the chunk MSB XOR carry out of the chunk MSB. This is two's-complement overflow of the full-width add.
  - out_ovf is valid with out_valid and resets to 0.
- MWADD_OVF_EN undefined: no out_ovf port, no ovf register. All other behaviour is identical.

## Structure
- Package mwadd_pkg holds:
  - state enum mwadd_state_e (IDLE, RUN, DONE)
  - localparam/function for the idx width
- Sub-module mwadd_chunk: combinational WIDTH-bit adder.
  - Inputs a, b, cin; outputs s and cout.
  - Also outputs msb_cin, used only under MWADD_OVF_EN.
- Chunk select is an indexed part-select on the operand registers. The sum write is an indexed part-select into the sum register.

## Test plan
- a=32'h0000_00FF, b=32'h0000_0001, cin=0 (WIDTH=8, WORDS=4) -> out_sum=32'h0000_0100, out_cout=0; out_valid rises 4 cycles after acceptance.
- a=32'hFFFF_FFFF, b=0, cin=1 -> carry ripples through all chunks: out_sum=0, out_cout=1.
- Result out_sum=32'h1234_5678 with out_ready held low 5 cycles -> out_valid, out_sum and out_cout stay stable and in_ready stays 0. The transfer happens on the first edge with out_ready high.
- A second in_valid presented during RUN is ignored. It is accepted only after the first result transfers, and both sums are correct.
- rst driven low during the 2nd RUN cycle -> all outputs at reset values and in_ready=1. After release, a=1, b=2 gives out_sum=3.
- MWADD_OVF_EN defined: a=32'h7FFF_FFFF, b=1 -> out_sum=32'h8000_0000, out_ovf=1, out_cout=0. Then a=32'hFFFF_FFFF, b=1 -> out_ovf=0, out_cout=1.
